ram_march_bist: RTL and testbench

RAM_MARCH_BIST -- requirements
Module: ram_march_bist

---
 rtl/ram_march_bist.sv | 169 ++++++++++++++++
 tb/tb_ram_march_bist.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_march_bist.sv
// March C- BIST engine driving a single-port RAM (RD_LAT 0 = async read, 1 = registered read).
// Optional first-error capture and mismatch counter when BIST_ERR_CAPTURE_EN is defined.
//
// state | meaning
// IDLE  | waiting for start; RAM interface parked at zero
// WRITE | one-cycle write op at addr
// READ  | read issue cycle; compare here when RD_LAT=0
// WAIT  | read latency cycle (RD_LAT=1 only); compare here
// NEXT  | reserved step state; the address/element step is folded into the
//       | final op cycle of each address, so it never occupies a cycle
// DONE  | one-cycle completion pulse
module ram_march_bist #(
  parameter int DEPTH  = 32,
  parameter int AW     = 5,
  parameter int DW     = 4,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          fail,
  output logic          ram_we,
  output logic [AW-1:0] ram_a,
  output logic [DW-1:0] ram_di,
  input  logic [DW-1:0] ram_dataout
`ifdef BIST_ERR_CAPTURE_EN
  ,
  output logic [AW-1:0] err_addr,
  output logic [DW-1:0] err_exp,
  output logic [DW-1:0] err_act,
  output logic [7:0]    err_cnt
`endif
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, WAIT, NEXT, DONE} state_t;

  localparam bit            LAT1   = (RD_LAT != 0);
  localparam logic [AW-1:0] LAST_A = AW'(DEPTH - 1);

  state_t        state, state_nx;
  state_t        adv_state;
  logic [2:0]    elem, elem_nx, adv_elem;
  logic [AW-1:0] addr, addr_nx, adv_addr;
  logic          down, at_last, rd_ones, wr_ones;
  logic          cmp_en, mism, accept;
  logic [DW-1:0] exp_rd;

  // Element decode: E0..E2 ascend, E3..E5 descend; E2/E4 read ones, E1/E3 write ones.
  always_comb begin
    down    = (elem >= 3'd3);
    at_last = down ? (addr == '0) : (addr == LAST_A);
    rd_ones = (elem == 3'd2) || (elem == 3'd4);
    wr_ones = (elem == 3'd1) || (elem == 3'd3);
    exp_rd  = rd_ones ? '1 : '0;
  end

  // Where the sequence goes once the last op at the current address finishes.
  always_comb begin
    adv_state = READ;
    adv_elem  = elem;
    adv_addr  = addr;
    if (at_last) begin
      if (elem == 3'd5) begin
        adv_state = DONE;
        adv_addr  = '0;
      end else begin
        adv_elem = elem + 3'd1;
        adv_addr = (elem >= 3'd2) ? LAST_A : '0;
      end
    end else begin
      adv_addr = down ? (addr - AW'(1)) : (addr + AW'(1));
      if (elem == 3'd0) adv_state = WRITE;
    end
  end

  always_comb begin
    state_nx = state;
    elem_nx  = elem;
    addr_nx  = addr;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = WRITE;
          elem_nx  = '0;
          addr_nx  = '0;
        end
      end
      WRITE: begin
        state_nx = adv_state;
        elem_nx  = adv_elem;
        addr_nx  = adv_addr;
      end
      READ: begin
        if (LAT1) begin
          state_nx = WAIT;
        end else if (elem == 3'd5) begin
          state_nx = adv_state;
          elem_nx  = adv_elem;
          addr_nx  = adv_addr;
        end else begin
          state_nx = WRITE;
        end
      end
      WAIT: begin
        if (elem == 3'd5) begin
          state_nx = adv_state;
          elem_nx  = adv_elem;
          addr_nx  = adv_addr;
        end else begin
          state_nx = WRITE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    accept = (state == IDLE) && start;
    cmp_en = (state == WAIT) || ((state == READ) && !LAT1);
    mism   = cmp_en && (ram_dataout != exp_rd);
    busy   = (state == WRITE) || (state == READ) || (state == WAIT);
    done   = (state == DONE);
    ram_we = (state == WRITE);
    ram_a  = busy ? addr : '0;
    ram_di = ((state == WRITE) && wr_ones) ? '1 : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      elem  <= '0;
      addr  <= '0;
      fail  <= 1'b0;
    end else begin
      state <= state_nx;
      elem  <= elem_nx;
      addr  <= addr_nx;
      if (accept)    fail <= 1'b0;
      else if (mism) fail <= 1'b1;
    end
  end

`ifdef BIST_ERR_CAPTURE_EN
  // err_cnt==0 marks the first mismatch of a run; the counter saturates at 255.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_addr <= '0;
      err_exp  <= '0;
      err_act  <= '0;
      err_cnt  <= '0;
    end else if (accept) begin
      err_addr <= '0;
      err_exp  <= '0;
      err_act  <= '0;
      err_cnt  <= '0;
    end else if (mism) begin
      if (err_cnt == 8'd0) begin
        err_addr <= addr;
        err_exp  <= exp_rd;
        err_act  <= ram_dataout;
      end
      if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ram_march_bist.sv
// Bench for ram_march_bist: one RD_LAT=1 instance with a registered-read RAM and one
// RD_LAT=0 instance with an async-read RAM; faults are injected in the RAM models.
module tb_ram_march_bist;
  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int DW    = 4;

  logic clk;
  logic rst_n;
  logic start1, start0;
  logic busy1, done1, fail1, ram_we1;
  logic busy0, done0, fail0, ram_we0;
  logic [AW-1:0] ram_a1, ram_a0;
  logic [DW-1:0] ram_di1, ram_di0, ram_do1, ram_do0;
`ifdef BIST_ERR_CAPTURE_EN
  logic [AW-1:0] err_addr1, err_addr0;
  logic [DW-1:0] err_exp1, err_exp0, err_act1, err_act0;
  logic [7:0]    err_cnt1, err_cnt0;
`endif

  logic [DW-1:0] mem1 [DEPTH];
  logic [DW-1:0] mem0 [DEPTH];

  // fkind: 0 none, 1 stuck bit fbit=fval at fa, 2 a write to fa also writes fb
  int fkind, fa, fb, fbit;
  bit fval;

  int n_tests, n_fail;

  ram_march_bist #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .RD_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1), .fail(fail1),
    .ram_we(ram_we1), .ram_a(ram_a1), .ram_di(ram_di1), .ram_dataout(ram_do1)
`ifdef BIST_ERR_CAPTURE_EN
    , .err_addr(err_addr1), .err_exp(err_exp1), .err_act(err_act1), .err_cnt(err_cnt1)
`endif
  );

  ram_march_bist #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .RD_LAT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .busy(busy0), .done(done0), .fail(fail0),
    .ram_we(ram_we0), .ram_a(ram_a0), .ram_di(ram_di0), .ram_dataout(ram_do0)
`ifdef BIST_ERR_CAPTURE_EN
    , .err_addr(err_addr0), .err_exp(err_exp0), .err_act(err_act0), .err_cnt(err_cnt0)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin : ram1_p
    logic [DW-1:0] rv;
    rv = mem1[ram_a1];
    if (fkind == 1 && int'(ram_a1) == fa) rv[fbit] = fval;
    ram_do1 <= rv;
    if (ram_we1) begin
      mem1[ram_a1] <= ram_di1;
      if (fkind == 2 && int'(ram_a1) == fa) mem1[fb] <= ram_di1;
    end
  end

  always @(posedge clk) begin
    if (ram_we0) begin
      mem0[ram_a0] <= ram_di0;
      if (fkind == 2 && int'(ram_a0) == fa) mem0[fb] <= ram_di0;
    end
  end

  always @* begin
    ram_do0 = mem0[ram_a0];
    if (fkind == 1 && int'(ram_a0) == fa) ram_do0[fbit] = fval;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // March C- played over an ideal array carrying the same fault, element by element.
  task automatic march_ref(output int cnt, output int e_addr, output int e_exp, output int e_act);
    logic [DW-1:0] m [DEPTH];
    logic [DW-1:0] ones, ev, av, wd;
    int a;
    ones = '1;
    cnt = 0; e_addr = 0; e_exp = 0; e_act = 0;
    for (int i = 0; i < DEPTH; i++) m[i] = '0;
    for (int el = 0; el < 6; el++) begin
      for (int k = 0; k < DEPTH; k++) begin
        a = (el >= 3) ? DEPTH - 1 - k : k;
        if (el > 0) begin
          ev = (el == 2 || el == 4) ? ones : '0;
          av = m[a];
          if (fkind == 1 && a == fa) av[fbit] = fval;
          if (av != ev) begin
            if (cnt == 0) begin
              e_addr = a; e_exp = int'(ev); e_act = int'(av);
            end
            cnt++;
          end
        end
        if (el < 5) begin
          wd = (el == 1 || el == 3) ? ones : '0;
          m[a] = wd;
          if (fkind == 2 && a == fa) m[fb] = wd;
        end
      end
    end
  endtask

  task automatic run_bist(input bit lat0, input int rp1, input int rp2,
                          output int bw, output int nd, output int dc, output bit fl, output bit ok);
    bit pb, b, d;
    bw = 0; nd = 0; dc = 0; fl = 0; ok = 1; pb = 0;
    if (lat0) start0 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
    for (int cyc = 1; cyc < 1500; cyc++) begin
      b = lat0 ? busy0 : busy1;
      d = lat0 ? done0 : done1;
      if (b) bw++;
      if (d) begin
        nd++;
        if (dc == 0) begin
          dc = cyc;
          fl = lat0 ? fail0 : fail1;
        end
        if (!pb || b) ok = 0;
      end
      pb = b;
      if (dc != 0 && cyc >= dc + 3) break;
      if (cyc == rp1 || cyc == rp2) begin
        if (lat0) start0 = 1'b1; else start1 = 1'b1;
      end else begin
        start0 = 1'b0; start1 = 1'b0;
      end
      @(negedge clk);
    end
    start0 = 1'b0; start1 = 1'b0;
  endtask

  task automatic check_run(input string tag, input bit lat0, input int rp1, input int rp2);
    int bw, nd, dc, cnt, ea, ee, ev, lim;
    bit fl, ok;
    lim = lat0 ? 10 * DEPTH : 15 * DEPTH;
    march_ref(cnt, ea, ee, ev);
    run_bist(lat0, rp1, rp2, bw, nd, dc, fl, ok);
    chk({tag, ".busy_width"}, bw, lim);
    chk({tag, ".done_count"}, nd, 1);
    chk({tag, ".done_cycle"}, dc, lim + 1);
    chk({tag, ".done_after_busy"}, int'(ok), 1);
    chk({tag, ".fail"}, int'(fl), int'(cnt > 0));
    chk({tag, ".fail_sticky"}, int'(lat0 ? fail0 : fail1), int'(cnt > 0));
    chk({tag, ".idle_we"}, int'(lat0 ? ram_we0 : ram_we1), 0);
`ifdef BIST_ERR_CAPTURE_EN
    chk({tag, ".err_cnt"}, int'(lat0 ? err_cnt0 : err_cnt1), (cnt > 255) ? 255 : cnt);
    if (cnt > 0) begin
      chk({tag, ".err_addr"}, int'(lat0 ? err_addr0 : err_addr1), ea);
      chk({tag, ".err_exp"}, int'(lat0 ? err_exp0 : err_exp1), ee);
      chk({tag, ".err_act"}, int'(lat0 ? err_act0 : err_act1), ev);
    end
`endif
  endtask

  initial begin
    int bw, k;
    n_tests = 0; n_fail = 0;
    rst_n = 1'b0; start1 = 1'b0; start0 = 1'b0;
    fkind = 0; fa = 0; fb = 0; fbit = 0; fval = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      mem1[i] = DW'($urandom);
      mem0[i] = DW'($urandom);
    end
    repeat (3) @(negedge clk);
    chk("rst.busy", int'(busy1), 0);
    chk("rst.done", int'(done1), 0);
    chk("rst.fail", int'(fail1), 0);
    chk("rst.we", int'(ram_we1), 0);
    chk("rst.addr", int'(ram_a1), 0);
    chk("rst.di", int'(ram_di1), 0);
    rst_n = 1'b1;
    @(negedge clk);

    check_run("clean1", 0, 0, 0);

    fkind = 1; fa = 12; fbit = 0; fval = 1'b1;
    check_run("stuck12", 0, 0, 0);
    for (int t = 0; t < 3; t++) begin
      fa = $urandom_range(0, DEPTH - 1);
      fbit = $urandom_range(0, DW - 1);
      fval = 1'($urandom_range(0, 1));
      check_run("stuck_rand", 0, 0, 0);
    end

    fkind = 0;
    check_run("clean_after_fail", 0, 0, 0);
    check_run("repulse", 0, 50, 300);
    check_run("repulse_rand", 0, $urandom_range(1, 15 * DEPTH), $urandom_range(1, 15 * DEPTH + 1));

    // reset in the middle of a failing run
    fkind = 1; fa = $urandom_range(0, DEPTH - 1); fbit = $urandom_range(0, DW - 1); fval = 1'b1;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (199) @(negedge clk);
    chk("midrun.fail_before_reset", int'(fail1), 1);
    chk("midrun.busy_before_reset", int'(busy1), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrun.busy", int'(busy1), 0);
    chk("midrun.we", int'(ram_we1), 0);
    chk("midrun.fail", int'(fail1), 0);
    chk("midrun.done", int'(done1), 0);
    chk("midrun.addr", int'(ram_a1), 0);
`ifdef BIST_ERR_CAPTURE_EN
    chk("midrun.err_cnt", int'(err_cnt1), 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset.we", int'(ram_we1), 0);
    chk("post_reset.busy", int'(busy1), 0);
    fkind = 0;
    check_run("after_reset", 0, 0, 0);

    // start held high through the whole run re-arms in the IDLE cycle after DONE
    start1 = 1'b1;
    bw = 0; k = 0;
    @(negedge clk);
    while (!done1 && k < 1500) begin
      if (busy1) bw++;
      k++;
      @(negedge clk);
    end
    chk("hold.busy_width", bw, 15 * DEPTH);
    chk("hold.done_seen", int'(done1), 1);
    @(negedge clk);
    chk("hold.idle_busy", int'(busy1), 0);
    @(negedge clk);
    chk("hold.restart_busy", int'(busy1), 1);
    start1 = 1'b0;
    bw = 0; k = 0;
    while (busy1 && k < 1500) begin
      bw++;
      k++;
      @(negedge clk);
    end
    chk("hold.second_width", bw, 15 * DEPTH);
    chk("hold.second_done", int'(done1), 1);
    repeat (2) @(negedge clk);

    check_run("lat0_clean", 1, 0, 0);
    fkind = 1; fa = $urandom_range(0, DEPTH - 1); fbit = $urandom_range(0, DW - 1);
    fval = 1'($urandom_range(0, 1));
    check_run("lat0_stuck", 1, 0, 0);

    fkind = 2; fa = 7; fb = 3;
    check_run("couple7_3", 0, 0, 0);
    check_run("lat0_couple7_3", 1, 0, 0);
    for (int t = 0; t < 2; t++) begin
      fa = $urandom_range(0, DEPTH - 1);
      fb = (fa + $urandom_range(1, DEPTH - 1)) % DEPTH;
      check_run("couple_rand", t[0], 0, 0);
    end
    fkind = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
